// File: rtl/npu_pkg.sv
// npu_pkg: shared widths, int8 limits and the round/ReLU/saturate helper for the requant path
package npu_pkg;
    localparam int ACC_W    = 24;
    localparam int MULT_W   = 16;
    localparam int SHIFT_W  = 5;
    localparam int OUT_W    = 8;
    localparam int LANES    = 4;
    localparam int SUM_W    = ACC_W + 1;
    localparam int PROD_W   = ACC_W + MULT_W + 2;
    localparam int CNT_W    = $clog2(LANES);
    localparam int INT8_MAX = (1 << (OUT_W - 1)) - 1;
    localparam int INT8_MIN = -(1 << (OUT_W - 1));

    // One extra bit of headroom keeps the rounding add from wrapping on the largest products.
    function automatic logic [OUT_W-1:0] round_sat(
        input logic signed [PROD_W-1:0]  p,
        input logic        [SHIFT_W-1:0] sh,
        input logic                      relu
    );
        logic signed [PROD_W:0] r;
        r = PROD_W'(p) == p ? {p[PROD_W-1], p} : {p[PROD_W-1], p};
        if (sh != '0)
            r = (r + $signed((PROD_W+1)'(1) << (sh - SHIFT_W'(1)))) >>> sh;
        if (relu && r < 0)
            r = '0;
        return (r > INT8_MAX) ? OUT_W'(INT8_MAX) :
               (r < INT8_MIN) ? OUT_W'(INT8_MIN) : r[OUT_W-1:0];
    endfunction
endpackage

// File: rtl/requant_core.sv
// requant_core: bias add, scale multiply and round/saturate stages with valid and flush sidebands
module requant_core
    import npu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               in_valid,
    input  logic               in_flush,
    input  logic [ACC_W-1:0]   in_data,
    input  logic [ACC_W-1:0]   cfg_bias,
    input  logic [MULT_W-1:0]  cfg_mult,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic               cfg_relu,
    output logic               out_valid,
    output logic               out_flush,
    output logic [OUT_W-1:0]   out_lane,
    output logic               active
);
    logic                     s1_valid, s1_flush, s2_valid, s2_flush;
    logic signed [SUM_W-1:0]  s1_b;
    logic signed [PROD_W-1:0] s2_p;

    assign active = s1_valid | s1_flush | s2_valid | s2_flush | out_valid | out_flush;

    // Three-stage datapath; every stage freezes together while the output is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_flush  <= 1'b0;
            s2_valid  <= 1'b0;
            s2_flush  <= 1'b0;
            out_valid <= 1'b0;
            out_flush <= 1'b0;
        end else if (!stall) begin
            s1_valid  <= in_valid;
            s1_flush  <= in_flush;
            s1_b      <= SUM_W'($signed(in_data)) + SUM_W'($signed(cfg_bias));
            s2_valid  <= s1_valid;
            s2_flush  <= s1_flush;
            s2_p      <= PROD_W'(s1_b) * PROD_W'($signed({1'b0, cfg_mult}));
            out_valid <= s2_valid;
            out_flush <= s2_flush;
            out_lane  <= round_sat(s2_p, cfg_shift, cfg_relu);
        end
    end
endmodule

// File: rtl/pe_requant_pack.sv
// pe_requant_pack: requantises PE results to int8 and packs four lanes per 32-bit output word
module pe_requant_pack
    import npu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ACC_W-1:0]       pe_outdata,
    input  logic                   pe_done,
    output logic                   pe_ready,
    input  logic                   flush,
    input  logic [ACC_W-1:0]       cfg_bias,
    input  logic [MULT_W-1:0]      cfg_mult,
    input  logic [SHIFT_W-1:0]     cfg_shift,
    input  logic                   cfg_relu,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic [LANES-1:0]       out_keep,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy
);
    logic                             stall, c_valid, c_flush, c_active, full, emit;
    logic [OUT_W-1:0]                 c_lane;
    logic [LANES-1:0][OUT_W-1:0]      lanes, lanes_n, word;
    logic [CNT_W-1:0]                 cnt, cnt_n;
    logic [LANES-1:0]                 keep_n;

    assign stall    = out_valid & ~out_ready;
    assign pe_ready = ~stall;
    assign busy     = c_active | (cnt != '0) | out_valid;

    requant_core u_core (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .in_valid  (pe_done & pe_ready),
        .in_flush  (flush & pe_ready),
        .in_data   (pe_outdata),
        .cfg_bias  (cfg_bias),
        .cfg_mult  (cfg_mult),
        .cfg_shift (cfg_shift),
        .cfg_relu  (cfg_relu),
        .out_valid (c_valid),
        .out_flush (c_flush),
        .out_lane  (c_lane),
        .active    (c_active)
    );

    // Sample lands first, then an attached flush closes whatever is left; a count that wraps to zero means the word already went out full.
    always_comb begin
        lanes_n = lanes;
        if (c_valid)
            lanes_n[cnt] = c_lane;
        cnt_n  = c_valid ? cnt + CNT_W'(1) : cnt;
        full   = c_valid && (cnt == CNT_W'(LANES - 1));
        emit   = full || (c_flush && cnt_n != '0);
        keep_n = full ? '1 : LANES'((1 << cnt_n) - 1);
        for (int i = 0; i < LANES; i++)
            word[i] = keep_n[i] ? lanes_n[i] : '0;
    end

    // Lane buffer and output register advance only when the consumer is not holding us off.
    always_ff @(posedge clk) begin
        if (rst) begin
            lanes     <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
        end else if (!stall) begin
            lanes     <= lanes_n;
            cnt       <= emit ? '0 : cnt_n;
            out_valid <= emit;
            if (emit) begin
                out_data <= word;
                out_keep <= keep_n;
            end
        end
    end
endmodule
